switch_debounce: RTL and testbench

//  Conditions the 24 raw board slide switches before they reach the 0x070 switch read port.

---
 rtl/switch_debounce.sv | 98 +++++++++
 tb/tb_switch_debounce.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/switch_debounce.sv
// Synchronises and debounces WIDTH raw slide switches on a shared prescaler tick.
// Optional SW_CHANGE_LATCH_EN adds a sticky change_pending flag cleared by change_ack.
module switch_debounce #(
   parameter int WIDTH      = 24,
   parameter int TICK_DIV   = 50000,
   parameter int STABLE_CNT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] sw_raw,
   output logic [WIDTH-1:0] sw_clean,
   output logic             sw_changed,
   output logic             change_pending,
   input  logic             change_ack
);

   localparam int TCW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int CW  = $clog2(STABLE_CNT + 1);
   localparam logic [TCW-1:0] TICK_LAST = TCW'(TICK_DIV - 1);
   localparam logic [CW-1:0]  CNT_LAST  = CW'(STABLE_CNT - 1);

   logic [WIDTH-1:0]          s1_q, s2_q;
   logic [WIDTH-1:0]          sw_clean_q, sw_clean_d;
   logic [WIDTH-1:0]          flip;
   logic [TCW-1:0]            tcnt_q, tcnt_d;
   logic [WIDTH-1:0][CW-1:0]  cnt_q, cnt_d;
   logic                      tick;
   logic                      changed_q, changed_d;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      tick       = (tcnt_q == TICK_LAST);
      tcnt_d     = tick ? '0 : tcnt_q + 1'b1;
      sw_clean_d = sw_clean_q;
      cnt_d      = cnt_q;
      flip       = '0;
      if (tick) begin
         for (int i = 0; i < WIDTH; i++) begin
            if (s2_q[i] == sw_clean_q[i]) begin
               cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
               sw_clean_d[i] = s2_q[i];
               cnt_d[i]      = '0;
               flip[i]       = 1'b1;
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
      changed_d = |flip;
   end

   // NOTE: state uses non-blocking assignments so all flops update from pre-edge values.
   // NOTE: the per-bit counter array is reset too, so a reset discards any partial count.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q       <= '0;
         s2_q       <= '0;
         tcnt_q     <= '0;
         cnt_q      <= '0;
         sw_clean_q <= '0;
         changed_q  <= 1'b0;
      end else begin
         s1_q       <= sw_raw;
         s2_q       <= s1_q;
         tcnt_q     <= tcnt_d;
         cnt_q      <= cnt_d;
         sw_clean_q <= sw_clean_d;
         changed_q  <= changed_d;
      end
   end

   assign sw_clean   = sw_clean_q;
   assign sw_changed = changed_q;

`ifdef SW_CHANGE_LATCH_EN
   logic pending_q, pending_d;

   // A change pulse beats an acknowledge arriving in the same cycle.
   always_comb begin
      pending_d = pending_q;
      if (change_ack) pending_d = 1'b0;
      if (changed_q)  pending_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) pending_q <= 1'b0;
      else     pending_q <= pending_d;
   end

   assign change_pending = pending_q;
`else
   logic unused_ack;
   assign unused_ack     = change_ack;
   assign change_pending = 1'b0;
`endif

endmodule

// File: tb/tb_switch_debounce.sv
// Scoreboard bench for switch_debounce (TICK_DIV=4, STABLE_CNT=3, WIDTH=24).
// Expected sw_clean values are queued at stimulus time and popped on each sw_changed pulse.
module tb_switch_debounce;

   localparam int WIDTH      = 24;
   localparam int TICK_DIV   = 4;
   localparam int STABLE_CNT = 3;
   localparam int LAT_MIN    = 2 + (STABLE_CNT - 1) * TICK_DIV + 1;
   localparam int LAT_MAX    = 2 + STABLE_CNT * TICK_DIV + 1;

`ifdef SW_CHANGE_LATCH_EN
   localparam logic PEND_ON = 1'b1;
`else
   localparam logic PEND_ON = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic [WIDTH-1:0] sw_raw;
   logic [WIDTH-1:0] sw_clean;
   logic             sw_changed;
   logic             change_pending;
   logic             change_ack;

   int               n_tests = 0;
   int               n_fail  = 0;
   int               cyc     = 0;
   int               n_changes = 0;
   int               last_chg_cyc = 0;
   logic [WIDTH-1:0] exp_q[$];

   switch_debounce #(
      .WIDTH(WIDTH), .TICK_DIV(TICK_DIV), .STABLE_CNT(STABLE_CNT)
   ) dut (
      .clk(clk), .rst(rst), .sw_raw(sw_raw), .sw_clean(sw_clean),
      .sw_changed(sw_changed), .change_pending(change_pending), .change_ack(change_ack)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Scoreboard consumer: every debounced edge must match the oldest queued expectation.
   always @(negedge clk) begin
      if (rst === 1'b0 && sw_changed === 1'b1) begin
         n_changes++;
         last_chg_cyc = cyc;
         if (exp_q.size() == 0) check("spurious_change", 32'(sw_changed), 32'd0);
         else check("clean_on_change", 32'(sw_clean), 32'(exp_q.pop_front()));
      end
   end

   task automatic do_reset(input int cycles);
      @(negedge clk);
      rst = 1'b1;
      repeat (cycles) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_drain(input string tag, input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      #1;
      check(tag, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic check_latency(input string tag, input int t0);
      int lat;
      lat = last_chg_cyc - t0;
      check(tag, 32'((lat >= LAT_MIN) && (lat <= LAT_MAX)), 32'd1);
   endtask

   initial begin
      int t0;
      int base;
      int n;

      // 1. Reset with all switches on.
      rst = 1'b1; sw_raw = '1; change_ack = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_clean",   32'(sw_clean), 32'd0);
      check("rst_changed", 32'(sw_changed), 32'd0);
      check("rst_pending", 32'(change_pending), 32'd0);
      sw_raw = '0;
      rst    = 1'b0;
      repeat (10) @(negedge clk);
      check("idle_clean", 32'(sw_clean), 32'd0);

      // 2. Clean step on bit 0.
      base = n_changes;
      t0 = cyc;
      sw_raw = 24'h000001;
      exp_q.push_back(24'h000001);
      wait_drain("step_drain", 30);
      check_latency("step_latency", t0);
      repeat (20) @(negedge clk);
      check("step_clean", 32'(sw_clean), 32'h000001);
      check("step_pulses", 32'(n_changes - base), 32'd1);

      // 6a. Sticky flag after the step, cleared by one acknowledge cycle.
      check("pend_after_step", 32'(change_pending), 32'(PEND_ON));
      change_ack = 1'b1;
      @(negedge clk);
      change_ack = 1'b0;
      @(negedge clk);
      check("pend_after_ack", 32'(change_pending), 32'd0);

      // 3. Bounce on bit 0 never survives three consecutive ticks.
      do_reset(2);
      repeat (4) @(negedge clk);
      base = n_changes;
      repeat (8) begin
         sw_raw = 24'h000001;
         repeat (3) @(negedge clk);
         sw_raw = 24'h000000;
         repeat (5) @(negedge clk);
      end
      repeat (10) @(negedge clk);
      check("bounce_clean",  32'(sw_clean), 32'd0);
      check("bounce_pulses", 32'(n_changes - base), 32'd0);

      // 4. Multi-bit pattern flips together with one pulse.
      base = n_changes;
      t0 = cyc;
      sw_raw = 24'hA5A5A5;
      exp_q.push_back(24'hA5A5A5);
      wait_drain("multi_drain", 30);
      check_latency("multi_latency", t0);
      repeat (20) @(negedge clk);
      check("multi_clean",  32'(sw_clean), 32'hA5A5A5);
      check("multi_pulses", 32'(n_changes - base), 32'd1);

      // 5. Reset in the middle of a count discards the partial progress.
      do_reset(2);
      base = n_changes;
      sw_raw = 24'h800000;
      repeat (9) @(negedge clk);
      check("midcnt_pre_rst", 32'(sw_clean), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      check("midcnt_in_rst", 32'(sw_clean), 32'd0);
      t0 = cyc;
      rst = 1'b0;
      exp_q.push_back(24'h800000);
      wait_drain("midcnt_drain", 30);
      check_latency("midcnt_latency", t0);
      check("midcnt_pulses", 32'(n_changes - base), 32'd1);

      // 6b. Acknowledge coinciding with a fresh change pulse leaves the flag set.
      change_ack = 1'b1;
      @(negedge clk);
      check("pend_cleared", 32'(change_pending), 32'd0);
      sw_raw = '0;
      exp_q.push_back(24'h000000);
      n = 0;
      while (sw_changed !== 1'b1 && n < 30) begin
         @(negedge clk);
         n++;
      end
      check("ack_pulse_seen", 32'(sw_changed), 32'd1);
      @(posedge clk);
      #1 change_ack = 1'b0;
      @(negedge clk);
      check("pend_set_wins", 32'(change_pending), 32'(PEND_ON));
      repeat (3) @(negedge clk);
      check("pend_held", 32'(change_pending), 32'(PEND_ON));
      check("final_clean", 32'(sw_clean), 32'd0);
      wait_drain("final_drain", 5);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: sim time exceeded at cycle %0d", cyc);
      $fatal(1, "timeout");
   end

endmodule
